// File: rtl/coin_pkg.sv
// coin_pkg: coin codes, hopper count and helpers shared by the hopper driver.
`default_nettype none

package coin_pkg;

  localparam int COIN_WIDTH  = 3;
  localparam int NUM_HOPPERS = 5;

  typedef enum logic [COIN_WIDTH-1:0] {
    COIN_NONE = 3'd0,
    NICKEL    = 3'd1,
    DIME      = 3'd2,
    QUARTER   = 3'd3,
    HALF      = 3'd4,
    DOLLAR    = 3'd5
  } coin_t;

  localparam int unsigned coin_value_nickels [6] = '{0, 1, 2, 5, 10, 20};

  function automatic logic coin_legal(input coin_t c);
    return (c >= NICKEL) && (c <= DOLLAR);
  endfunction

  function automatic logic [NUM_HOPPERS-1:0] coin_onehot(input coin_t c);
    logic [NUM_HOPPERS-1:0] oh;
    case (c)
      NICKEL:  oh = 5'b00001;
      DIME:    oh = 5'b00010;
      QUARTER: oh = 5'b00100;
      HALF:    oh = 5'b01000;
      DOLLAR:  oh = 5'b10000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hopper_timer.sv
// hopper_timer: loadable down-counter; expired is high while the count sits at zero.
`default_nettype none

module hopper_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

`default_nettype wire

// File: rtl/coin_hopper_driver.sv
// coin_hopper_driver: pays out one coin per accepted code by pulsing its hopper and
// confirming the drop sensor, with retries, a sticky fault and a saturating payout count.
`default_nettype none

module coin_hopper_driver
  import coin_pkg::*;
#(
  parameter int FIRE_CYCLES  = 8,
  parameter int DROP_TIMEOUT = 256,
  parameter int GAP_CYCLES   = 4,
  parameter int MAX_RETRIES  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [COIN_WIDTH-1:0]  change_msg,
  input  logic                   change_val,
  output logic                   change_rdy,
  output logic [NUM_HOPPERS-1:0] hopper_fire,
  input  logic [NUM_HOPPERS-1:0] hopper_drop,
  input  logic                   fault_clear,
  output logic                   busy,
  output logic                   fault,
  output logic [COIN_WIDTH-1:0]  fault_coin,
  output logic                   bad_code,
  output logic                   stray_drop,
  output logic [15:0]            coins_out
);

  localparam int TW = 16;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRE  = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t                 state;
  coin_t                  code;
  logic [RW-1:0]          retry_cnt;
  logic [NUM_HOPPERS-1:0] drop_prev;

  logic                   timer_load;
  logic [TW-1:0]          timer_value;
  logic                   timer_expired;

  coin_t                  msg_coin;
  logic                   msg_legal;
  logic                   transfer;
  logic                   active;
  logic [NUM_HOPPERS-1:0] target;
  logic [NUM_HOPPERS-1:0] drop_edge;
  logic                   hit;
  logic                   stray_now;
  logic                   can_retry;

  assign msg_coin  = coin_t'(change_msg);
  assign msg_legal = coin_legal(msg_coin);
  assign transfer  = change_val && change_rdy;
  assign active    = (state == S_FIRE) || (state == S_WAIT);
  assign target    = active ? coin_onehot(code) : '0;
  assign drop_edge = hopper_drop & ~drop_prev;
  assign hit       = |(drop_edge & target);
  assign stray_now = |(drop_edge & ~target);
  assign can_retry = (retry_cnt < RW'(MAX_RETRIES));

  // Timer is reloaded on every state entry that needs a bounded dwell.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      S_IDLE: begin
        timer_load  = transfer && msg_legal;
        timer_value = TW'(FIRE_CYCLES - 1);
      end
      S_FIRE: begin
        timer_load  = hit || timer_expired;
        timer_value = hit ? TW'(GAP_CYCLES - 1) : TW'(DROP_TIMEOUT - 1);
      end
      S_WAIT: begin
        timer_load  = hit || (timer_expired && can_retry);
        timer_value = hit ? TW'(GAP_CYCLES - 1) : TW'(FIRE_CYCLES - 1);
      end
      default: begin
        timer_load  = 1'b0;
        timer_value = '0;
      end
    endcase
  end

  hopper_timer #(.WIDTH(TW)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      code        <= COIN_NONE;
      retry_cnt   <= '0;
      drop_prev   <= '0;
      change_rdy  <= 1'b1;
      hopper_fire <= '0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      fault_coin  <= '0;
      bad_code    <= 1'b0;
      stray_drop  <= 1'b0;
      coins_out   <= '0;
    end else begin
      drop_prev  <= hopper_drop;
      stray_drop <= stray_now;
      bad_code   <= 1'b0;
      if (hit && (coins_out != 16'hFFFF)) begin
        coins_out <= coins_out + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (transfer) begin
            if (msg_legal) begin
              code        <= msg_coin;
              retry_cnt   <= '0;
              state       <= S_FIRE;
              hopper_fire <= coin_onehot(msg_coin);
              change_rdy  <= 1'b0;
              busy        <= 1'b1;
            end else begin
              bad_code <= 1'b1;
            end
          end
        end
        S_FIRE: begin
          if (hit) begin
            state       <= S_GAP;
            hopper_fire <= '0;
          end else if (timer_expired) begin
            state       <= S_WAIT;
            hopper_fire <= '0;
          end
        end
        S_WAIT: begin
          // A drop on the expiry cycle still counts as a payout.
          if (hit) begin
            state <= S_GAP;
          end else if (timer_expired) begin
            if (can_retry) begin
              retry_cnt   <= retry_cnt + 1'b1;
              state       <= S_FIRE;
              hopper_fire <= coin_onehot(code);
            end else begin
              state      <= S_FAULT;
              fault      <= 1'b1;
              fault_coin <= code;
            end
          end
        end
        S_GAP: begin
          if (timer_expired) begin
            state      <= S_IDLE;
            change_rdy <= 1'b1;
            busy       <= 1'b0;
          end
        end
        S_FAULT: begin
          if (fault_clear) begin
            state      <= S_IDLE;
            fault      <= 1'b0;
            fault_coin <= '0;
            change_rdy <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          hopper_fire <= '0;
          change_rdy  <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_coin_hopper_driver.sv
// tb_coin_hopper_driver: directed and randomized payouts checked against a timeline model
// of each coin (fire windows, drop cycle, gap, fault point).
`default_nettype none

module tb_coin_hopper_driver;

  localparam int F = 8;
  localparam int D = 256;
  localparam int G = 4;
  localparam int M = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  change_msg = 3'd0;
  logic        change_val = 1'b0;
  logic        change_rdy;
  logic [4:0]  hopper_fire;
  logic [4:0]  hopper_drop = 5'd0;
  logic        fault_clear = 1'b0;
  logic        busy;
  logic        fault;
  logic [2:0]  fault_coin;
  logic        bad_code;
  logic        stray_drop;
  logic [15:0] coins_out;

  int n_asrt    = 0;
  int n_fail    = 0;
  int exp_coins = 0;

  coin_hopper_driver #(
    .FIRE_CYCLES  (F),
    .DROP_TIMEOUT (D),
    .GAP_CYCLES   (G),
    .MAX_RETRIES  (M)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .change_msg  (change_msg),
    .change_val  (change_val),
    .change_rdy  (change_rdy),
    .hopper_fire (hopper_fire),
    .hopper_drop (hopper_drop),
    .fault_clear (fault_clear),
    .busy        (busy),
    .fault       (fault),
    .fault_coin  (fault_coin),
    .bad_code    (bad_code),
    .stray_drop  (stray_drop),
    .coins_out   (coins_out)
  );

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy();
    int k = 0;
    while (change_rdy !== 1'b1 && k < 3000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 3000) chk("rdy_timeout", {31'd0, change_rdy}, 32'd1);
  endtask

  // succ: attempt index that sees the drop (-1 = never); offs: cycle of the drop relative
  // to the start of that attempt's wait window (negative = inside the fire pulse).
  task automatic pay(input logic [2:0] code, input int succ, input int offs, input int stray_pick);
    int         j_succ, end_j, fault_j, stray_at;
    logic [4:0] tgt, sbit, exp_fire;
    bit         legal, ok_end;
    legal = (code >= 3'd1) && (code <= 3'd5);
    wait_rdy();
    change_msg = code;
    change_val = 1'b1;
    @(posedge clock);
    if (!legal) begin
      @(negedge clock);
      change_val = 1'b0;
      chk("bad_pulse", {31'd0, bad_code}, 32'd1);
      chk("bad_fire", {27'd0, hopper_fire}, 32'd0);
      chk("bad_rdy", {31'd0, change_rdy}, 32'd1);
      @(negedge clock);
      chk("bad_clear", {31'd0, bad_code}, 32'd0);
      chk("bad_busy", {31'd0, busy}, 32'd0);
      chk("bad_coins", {16'd0, coins_out}, exp_coins);
      return;
    end
    tgt      = 5'b00001 << (code - 3'd1);
    sbit     = (code == 3'd1) ? 5'b00010 : 5'b00001;
    fault_j  = 1 + (M + 1) * (F + D);
    j_succ   = (succ >= 0) ? 1 + succ * (F + D) + F + offs : 0;
    end_j    = (succ >= 0) ? j_succ + G + 1 : fault_j;
    stray_at = (stray_pick > 0) ? 1 + (stray_pick % (end_j - 1)) : 0;
    for (int j = 1; j <= end_j; j++) begin
      @(negedge clock);
      change_val = 1'b0;
      exp_fire = 5'd0;
      for (int a = 0; a <= M; a++) begin
        if (j >= 1 + a * (F + D) && j < 1 + a * (F + D) + F && (succ < 0 || j <= j_succ))
          exp_fire = tgt;
      end
      ok_end = (succ >= 0) && (j == end_j);
      chk("fire", {27'd0, hopper_fire}, {27'd0, exp_fire});
      chk("rdy", {31'd0, change_rdy}, {31'd0, ok_end});
      chk("busy", {31'd0, busy}, {31'd0, !ok_end});
      chk("fault", {31'd0, fault}, {31'd0, (succ < 0) && (j == end_j)});
      chk("stray", {31'd0, stray_drop}, {31'd0, (stray_at != 0) && (j == stray_at + 1)});
      hopper_drop = 5'd0;
      if (succ >= 0 && j == j_succ) hopper_drop = hopper_drop | tgt;
      if (j == stray_at) hopper_drop = hopper_drop | sbit;
    end
    if (succ >= 0) exp_coins++;
    chk("coins", {16'd0, coins_out}, exp_coins);
    if (succ < 0) chk("fault_coin", {29'd0, fault_coin}, {29'd0, code});
  endtask

  task automatic clear_fault(input logic [2:0] code);
    repeat (3) @(negedge clock);
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    chk("fault_coin_hold", {29'd0, fault_coin}, {29'd0, code});
    chk("fault_fire", {27'd0, hopper_fire}, 32'd0);
    chk("fault_rdy", {31'd0, change_rdy}, 32'd0);
    fault_clear = 1'b1;
    @(negedge clock);
    fault_clear = 1'b0;
    chk("clr_fault", {31'd0, fault}, 32'd0);
    chk("clr_fault_coin", {29'd0, fault_coin}, 32'd0);
    chk("clr_rdy", {31'd0, change_rdy}, 32'd1);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_coins", {16'd0, coins_out}, exp_coins);
  endtask

  initial begin
    logic [2:0] rcode;
    int         rsucc, roffs, rstray, kind;

    repeat (3) @(negedge clock);
    chk("rst_rdy", {31'd0, change_rdy}, 32'd1);
    chk("rst_fire", {27'd0, hopper_fire}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_coin", {29'd0, fault_coin}, 32'd0);
    chk("rst_bad", {31'd0, bad_code}, 32'd0);
    chk("rst_stray", {31'd0, stray_drop}, 32'd0);
    chk("rst_coins", {16'd0, coins_out}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_rdy", {31'd0, change_rdy}, 32'd1);

    // Single quarter, drop in third wait cycle.
    pay(3'd3, 0, 2, 0);
    // Back-to-back dollar, nickel, dime with drops in the first wait cycle.
    pay(3'd5, 0, 0, 0);
    pay(3'd1, 0, 0, 0);
    pay(3'd2, 0, 0, 0);
    // Dime that never drops: retries, fault, clear.
    pay(3'd2, -1, 0, 0);
    clear_fault(3'd2);
    fault_clear = 1'b1;
    @(negedge clock);
    fault_clear = 1'b0;
    @(negedge clock);
    chk("idle_clear_fault", {31'd0, fault}, 32'd0);
    chk("idle_clear_rdy", {31'd0, change_rdy}, 32'd1);
    // Half dollar dropping on the second attempt.
    pay(3'd4, 1, 1, 0);
    // Illegal codes.
    pay(3'd0, 0, 0, 0);
    pay(3'd7, 0, 0, 0);
    chk("ill_coins", {16'd0, coins_out}, exp_coins);
    // Stray edge on bit 0 while paying a quarter.
    pay(3'd3, 0, 4, 5);

    // Reset asserted mid-fire.
    wait_rdy();
    change_msg = 3'd3;
    change_val = 1'b1;
    @(negedge clock);
    change_val = 1'b0;
    chk("mid_fire", {27'd0, hopper_fire}, 32'd4);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_coins = 0;
    chk("mrst_rdy", {31'd0, change_rdy}, 32'd1);
    chk("mrst_fire", {27'd0, hopper_fire}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_fault", {31'd0, fault}, 32'd0);
    chk("mrst_fault_coin", {29'd0, fault_coin}, 32'd0);
    chk("mrst_bad", {31'd0, bad_code}, 32'd0);
    chk("mrst_stray", {31'd0, stray_drop}, 32'd0);
    chk("mrst_coins", {16'd0, coins_out}, 32'd0);
    @(negedge clock);
    chk("mrst_fire2", {27'd0, hopper_fire}, 32'd0);

    // Drops coinciding with timer expiry.
    pay(3'd1, 0, D - 1, 0);
    pay(3'd5, M, D - 1, 0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        rcode = 3'($urandom_range(1, 5));
      end else begin
        kind  = int'($urandom_range(0, 2));
        rcode = (kind == 0) ? 3'd0 : (kind == 1) ? 3'd6 : 3'd7;
      end
      rsucc = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, M));
      kind  = int'($urandom_range(0, 3));
      case (kind)
        0:       roffs = int'($urandom_range(0, 6));
        1:       roffs = D - 1;
        2:       roffs = -int'($urandom_range(1, F));
        default: roffs = int'($urandom_range(0, D - 1));
      endcase
      rstray = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 1000)) : 0;
      pay(rcode, rsucc, roffs, rstray);
      if (rsucc < 0 && rcode >= 3'd1 && rcode <= 3'd5) clear_fault(rcode);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
